// File: rtl/cpu_fetch_decode_if.sv
// Front-end bus of the LEGv8 fetch/decode slice: PC load path, fetched
// instruction and ALU flags in; current PC, control signals and immediates out.
interface cpu_fetch_decode_if;
  logic        pc_en;
  logic [63:0] pc_next;
  logic [31:0] instruction;
  logic        zero;
  logic        negative;
  logic        overflow;

  logic [63:0] pc;
  logic        Reg2Loc;
  logic        ALUsrc;
  logic        ALUsrc1;
  logic [2:0]  ALUOp;
  logic        MemtoReg;
  logic        RegWri;
  logic        MemWri;
  logic        Readmem;
  logic        BrTaken;
  logic        UncondBr;
  logic [63:0] DAddr9;
  logic [63:0] CondAddr19;
  logic [63:0] BrAddr26;
  logic [63:0] Imm12;

  // Driver side: the datapath around this slice (or a testbench)
  modport master (
    output pc_en, pc_next, instruction, zero, negative, overflow,
    input  pc, Reg2Loc, ALUsrc, ALUsrc1, ALUOp, MemtoReg, RegWri, MemWri,
           Readmem, BrTaken, UncondBr, DAddr9, CondAddr19, BrAddr26, Imm12
  );

  modport slave (
    input  pc_en, pc_next, instruction, zero, negative, overflow,
    output pc, Reg2Loc, ALUsrc, ALUsrc1, ALUOp, MemtoReg, RegWri, MemWri,
           Readmem, BrTaken, UncondBr, DAddr9, CondAddr19, BrAddr26, Imm12
  );
endinterface

// File: rtl/cpu_fetch_decode.sv
// LEGv8 single-cycle front end: PC register, main control decoder and
// immediate extension. Optional B.LT decode is enabled by macro CTRL_BLT_EN.
module cpu_fetch_decode (
  input logic              clk,
  input logic              reset,
  cpu_fetch_decode_if.slave bus
);

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;

  function automatic logic signed [63:0] sext9(input logic [8:0] v);
    return 64'(signed'(v));
  endfunction

  function automatic logic signed [63:0] sext19(input logic [18:0] v);
    return 64'(signed'(v));
  endfunction

  function automatic logic signed [63:0] sext26(input logic [25:0] v);
    return 64'(signed'(v));
  endfunction

  function automatic logic [63:0] zext12(input logic [11:0] v);
    return {52'd0, v};
  endfunction

  logic [10:0] opcode;
  logic        blt_cond;
  logic        unused_flags;

  assign opcode = bus.instruction[31:21];

`ifdef CTRL_BLT_EN
  assign blt_cond     = bus.negative ^ bus.overflow;
  assign unused_flags = 1'b0;
`else
  // Flags are ports in both builds but only feed the decoder with B.LT enabled
  assign blt_cond     = 1'b0;
  assign unused_flags = bus.negative ^ bus.overflow;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.pc <= 64'h0;
    end else if (bus.pc_en) begin
      bus.pc <= bus.pc_next;
    end
  end

  always_comb begin
    bus.Reg2Loc  = 1'b0;
    bus.ALUsrc   = 1'b0;
    bus.ALUsrc1  = 1'b0;
    bus.ALUOp    = ALU_PASS_B;
    bus.MemtoReg = 1'b0;
    bus.RegWri   = 1'b0;
    bus.MemWri   = 1'b0;
    bus.Readmem  = 1'b0;
    bus.BrTaken  = 1'b0;
    bus.UncondBr = 1'b0;

    // Opcode fields differ in width; wildcard low bits are instruction operands
    casez (opcode)
      11'b1001000100?: begin // ADDI
        bus.ALUsrc  = 1'b1;
        bus.ALUsrc1 = 1'b1;
        bus.RegWri  = 1'b1;
        bus.ALUOp   = ALU_ADD;
      end
      11'b10101011000: begin // ADDS
        bus.RegWri = 1'b1;
        bus.ALUOp  = ALU_ADD;
      end
      11'b11101011000: begin // SUBS
        bus.RegWri = 1'b1;
        bus.ALUOp  = ALU_SUB;
      end
      11'b11111000010: begin // LDUR
        bus.ALUsrc   = 1'b1;
        bus.MemtoReg = 1'b1;
        bus.RegWri   = 1'b1;
        bus.Readmem  = 1'b1;
        bus.ALUOp    = ALU_ADD;
      end
      11'b11111000000: begin // STUR
        bus.Reg2Loc = 1'b1;
        bus.ALUsrc  = 1'b1;
        bus.MemWri  = 1'b1;
        bus.ALUOp   = ALU_ADD;
      end
      11'b10110100???: begin // CBZ
        bus.Reg2Loc = 1'b1;
        bus.ALUOp   = ALU_PASS_B;
        bus.BrTaken = bus.zero;
      end
      11'b000101?????: begin // B
        bus.BrTaken  = 1'b1;
        bus.UncondBr = 1'b1;
      end
      11'b01010100???: begin // B.cond; only LT is recognised
        if (bus.instruction[4:0] == 5'b01011) begin
          bus.BrTaken = blt_cond;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.DAddr9     = sext9(bus.instruction[20:12]);
  assign bus.CondAddr19 = sext19(bus.instruction[23:5]);
  assign bus.BrAddr26   = sext26(bus.instruction[25:0]);
  assign bus.Imm12      = zext12(bus.instruction[21:10]);

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Directed self-checking bench for cpu_fetch_decode.
module tb_cpu_fetch_decode;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cpu_fetch_decode_if bus ();

  cpu_fetch_decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {Reg2Loc, ALUsrc, ALUsrc1, ALUOp, MemtoReg, RegWri, MemWri, Readmem, BrTaken, UncondBr}
  function automatic logic [11:0] ctrl();
    return {bus.Reg2Loc, bus.ALUsrc, bus.ALUsrc1, bus.ALUOp, bus.MemtoReg,
            bus.RegWri, bus.MemWri, bus.Readmem, bus.BrTaken, bus.UncondBr};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic z, input logic n, input logic v);
    @(negedge clk);
    bus.instruction = instr;
    bus.zero        = z;
    bus.negative    = n;
    bus.overflow    = v;
    #1;
  endtask

  task automatic test_reset();
    bus.pc_en   = 1'b1;
    bus.pc_next = 64'h40;
    bus.instruction = 32'h91000C22;
    bus.zero = 1'b0; bus.negative = 1'b0; bus.overflow = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 64'h0) begin errors++; $display("FAIL reset_async pc=%h exp=%h", bus.pc, 64'h0); end
    checks++;
    if (bus.RegWri !== 1'b1) begin errors++; $display("FAIL decode_in_reset RegWri=%b exp=1", bus.RegWri); end
    @(posedge clk); #1;
    checks++;
    if (bus.pc !== 64'h0) begin errors++; $display("FAIL reset_hold pc=%h exp=%h", bus.pc, 64'h0); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.pc !== 64'h40) begin errors++; $display("FAIL reset_release pc=%h exp=%h", bus.pc, 64'h40); end
    @(negedge clk);
    bus.pc_next = 64'h1234;
    @(posedge clk); #1;
    checks++;
    if (bus.pc !== 64'h1234) begin errors++; $display("FAIL pc_load pc=%h exp=%h", bus.pc, 64'h1234); end
    // Reset mid-cycle with a pending load must discard it
    @(negedge clk);
    bus.pc_next = 64'h88;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 64'h0) begin errors++; $display("FAIL reset_midcycle pc=%h exp=%h", bus.pc, 64'h0); end
    @(posedge clk); #1;
    checks++;
    if (bus.pc !== 64'h0) begin errors++; $display("FAIL reset_discard pc=%h exp=%h", bus.pc, 64'h0); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus.pc_next = 64'h500;
    @(posedge clk); #1;
    @(negedge clk);
    bus.pc_en   = 1'b0;
    bus.pc_next = 64'h99;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.pc !== 64'h500) begin errors++; $display("FAIL hold pc=%h exp=%h", bus.pc, 64'h500); end
    @(negedge clk);
    bus.pc_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.pc !== 64'h99) begin errors++; $display("FAIL hold_release pc=%h exp=%h", bus.pc, 64'h99); end
  endtask

  task automatic test_alu_ops();
    drive(32'h91000C22, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b011_010_0100_00) begin errors++; $display("FAIL addi_ctrl got=%b exp=%b", ctrl(), 12'b011_010_0100_00); end
    checks++;
    if (bus.Imm12 !== 64'h3) begin errors++; $display("FAIL addi_imm12 got=%h exp=%h", bus.Imm12, 64'h3); end
    drive(32'hAB020020, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b000_010_0100_00) begin errors++; $display("FAIL adds_ctrl got=%b exp=%b", ctrl(), 12'b000_010_0100_00); end
    drive(32'hEB020020, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b000_011_0100_00) begin errors++; $display("FAIL subs_ctrl got=%b exp=%b", ctrl(), 12'b000_011_0100_00); end
  endtask

  task automatic test_mem();
    drive(32'hF8408020, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b010_010_1101_00) begin errors++; $display("FAIL ldur_ctrl got=%b exp=%b", ctrl(), 12'b010_010_1101_00); end
    checks++;
    if (bus.DAddr9 !== 64'h8) begin errors++; $display("FAIL ldur_daddr9 got=%h exp=%h", bus.DAddr9, 64'h8); end
    drive(32'hF81F83E1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b110_010_0010_00) begin errors++; $display("FAIL stur_ctrl got=%b exp=%b", ctrl(), 12'b110_010_0010_00); end
    checks++;
    if (bus.DAddr9 !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL stur_daddr9 got=%h exp=%h", bus.DAddr9, 64'hFFFF_FFFF_FFFF_FFF8); end
  endtask

  task automatic test_branch();
    drive(32'hB4FFFFE0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b100_000_0000_10) begin errors++; $display("FAIL cbz_taken got=%b exp=%b", ctrl(), 12'b100_000_0000_10); end
    checks++;
    if (bus.CondAddr19 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL cbz_addr got=%h exp=%h", bus.CondAddr19, 64'hFFFF_FFFF_FFFF_FFFF); end
    drive(32'hB4FFFFE0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b100_000_0000_00) begin errors++; $display("FAIL cbz_not_taken got=%b exp=%b", ctrl(), 12'b100_000_0000_00); end
    drive(32'h17FFFFFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b000_000_0000_11) begin errors++; $display("FAIL b_ctrl got=%b exp=%b", ctrl(), 12'b000_000_0000_11); end
    checks++;
    if (bus.BrAddr26 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL b_addr got=%h exp=%h", bus.BrAddr26, 64'hFFFF_FFFF_FFFF_FFFF); end
  endtask

  task automatic test_nop_and_ext();
    drive(32'h00000000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ctrl() !== 12'b0) begin errors++; $display("FAIL nop_zero got=%b exp=%b", ctrl(), 12'b0); end
    // Immediate fields with positive sign bits and Imm12 MSB set
    drive(32'h003FFC00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl() !== 12'b0) begin errors++; $display("FAIL nop_other got=%b exp=%b", ctrl(), 12'b0); end
    checks++;
    if (bus.Imm12 !== 64'hFFF) begin errors++; $display("FAIL imm12_zext got=%h exp=%h", bus.Imm12, 64'hFFF); end
    checks++;
    if (bus.DAddr9 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL daddr9_neg got=%h exp=%h", bus.DAddr9, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++;
    if (bus.CondAddr19 !== 64'h1FFE0) begin errors++; $display("FAIL cond19_pos got=%h exp=%h", bus.CondAddr19, 64'h1FFE0); end
    checks++;
    if (bus.BrAddr26 !== 64'h3FFC00) begin errors++; $display("FAIL br26_pos got=%h exp=%h", bus.BrAddr26, 64'h3FFC00); end
  endtask

  task automatic test_blt();
    logic [11:0] exp_lt;
`ifdef CTRL_BLT_EN
    exp_lt = 12'b000_000_0000_10;
`else
    exp_lt = 12'b0;
`endif
    drive(32'h5400004B, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctrl() !== exp_lt) begin errors++; $display("FAIL blt_lt got=%b exp=%b", ctrl(), exp_lt); end
    drive(32'h5400004B, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctrl() !== 12'b0) begin errors++; $display("FAIL blt_ge got=%b exp=%b", ctrl(), 12'b0); end
    // Same class, other condition (B.EQ) is never decoded
    drive(32'h54000040, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctrl() !== 12'b0) begin errors++; $display("FAIL bcond_other got=%b exp=%b", ctrl(), 12'b0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hold();
    test_alu_ops();
    test_mem();
    test_branch();
    test_nop_and_ext();
    test_blt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_fetch_decode.md
# cpu_fetch_decode

Front-end slice of the single-cycle 64-bit LEGv8 CPU: the program-counter register, the main control decoder and the immediate-extension unit. It holds the current PC, and decodes the fetched 32-bit instruction (plus the ALU zero flag) into datapath control signals and four 64-bit extended immediates. These feed the register-file read-port mux, the ALU operand muxes, the data memory and the next-PC calculator. Next-PC arithmetic is outside this block.

## Interface
Parameters: none (widths fixed: 64-bit datapath, 32-bit instruction).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears PC
- pc_en  in  1  PC load enable (tied 1 in the CPU)
- pc_next  in  64  next PC from the PC calculator
- instruction  in  32  fetched instruction
- zero  in  1  ALU zero flag, same cycle
- negative, overflow  in  1 each  ALU flags, used only under CTRL_BLT_EN
- pc  out  64  current PC
- Reg2Loc  out  1  0: read port 2 = instruction[20:16] (Rm); 1: instruction[4:0] (Rd)
- ALUsrc  out  1  0: ALU B = register data 2; 1: B = extended immediate
- ALUsrc1  out  1  immediate select: 0 = DAddr9, 1 = Imm12
- ALUOp  out  3  ALU operation:
  - 000 pass B
  - 010 add
  - 011 subtract
- MemtoReg, RegWri, MemWri, Readmem  out  1 each  writeback-from-memory, register write, memory write, memory read
- BrTaken, UncondBr  out  1 each  take branch; 1 = use BrAddr26, 0 = use CondAddr19
- DAddr9, CondAddr19, BrAddr26, Imm12  out  64 each  extended immediates

## Operation
- Decode is combinational on instruction[31:21] and zero. Each opcode is matched on its full field width; the fields do not overlap.
- Any signal not listed for an opcode below is driven to 0.
- Instruction decode:
  - ADDI (instruction[31:22] = 1001000100): ALUsrc=1, ALUsrc1=1, RegWri=1, ALUOp=010.
  - ADDS (instruction[31:21] = 10101011000): RegWri=1, ALUOp=010.
  - SUBS (instruction[31:21] = 11101011000): RegWri=1, ALUOp=011.
  - LDUR (instruction[31:21] = 11111000010): ALUsrc=1, ALUsrc1=0, MemtoReg=1, RegWri=1, Readmem=1, ALUOp=010.
  - STUR (instruction[31:21] = 11111000000): Reg2Loc=1, ALUsrc=1, ALUsrc1=0, MemWri=1, ALUOp=010.
  - CBZ (instruction[31:24] = 10110100): Reg2Loc=1, ALUOp=000, BrTaken=zero, UncondBr=0.
  - B (instruction[31:26] = 000101): BrTaken=1, UncondBr=1.
  - Any other encoding: all outputs 0 (safe NOP: no register write, no memory access, no branch).
- Immediate extension, always computed regardless of opcode:
  - DAddr9 = sign-extend(instruction[20:12])
  - CondAddr19 = sign-extend(instruction[23:5])
  - BrAddr26 = sign-extend(instruction[25:0])
  - Imm12 = zero-extend(instruction[21:10])
- PC register: 64-bit, enabled D flip-flop.
  - pc_en=1: loads pc_next on each rising clk edge.
  - pc_en=0: holds its value.

## Timing
- Decode and extension outputs: zero-cycle (combinational) from instruction, zero, negative and overflow.
- reset does not affect decode or extension outputs.
- pc resets to 64'h0 immediately when reset falls, independent of clk. It stays 0 while reset=0.
- On the first rising edge after reset rises, pc loads pc_next (if pc_en=1).
- Reset asserted mid-cycle discards any pending load.
- pc_en and pc_next are sampled only at the rising edge.

## Configuration
- CTRL_BLT_EN defined: B.LT (instruction[31:24] = 01010100 and instruction[4:0] = 01011) is decoded as:
  - BrTaken = negative XOR overflow
  - UncondBr = 0
  - all other outputs 0
- CTRL_BLT_EN undefined: B.LT decodes as unknown (all outputs 0).
- The negative and overflow ports exist in both builds; they are ignored when the macro is undefined.

## Test plan
- Reset: pc_next=64'h40, pc_en=1, drive reset=0 between edges -> pc=0 immediately. Release reset -> pc=64'h40 after the next rising edge.
- Hold: pc_en=0, pc_next=64'h99 over 3 edges -> pc unchanged.
- ADDI 0x91000C22 -> ALUsrc=1, ALUsrc1=1, RegWri=1, ALUOp=010, Imm12=64'h3. STUR 0xF81F83E1 -> Reg2Loc=1, MemWri=1, DAddr9=64'hFFFF_FFFF_FFFF_FFF8.
- CBZ 0xB4FFFFE0:
  - zero=1 -> BrTaken=1, UncondBr=0, CondAddr19=all-ones
  - zero=0 -> BrTaken=0
- B 0x17FFFFFF -> BrTaken=1, UncondBr=1, BrAddr26=64'hFFFF_FFFF_FFFF_FFFF. Instruction 0x00000000 -> all controls 0.
- B.LT 0x5400004B with negative=1, overflow=0:
  - CTRL_BLT_EN defined -> BrTaken=1
  - undefined -> BrTaken=0, all controls 0
